seg7_scan_display: RTL and testbench
====================================

# seg7_scan_display

Time-multiplexed 8-digit seven-segment driver that sits directly downstream of the CPU top. It consumes the CPU's 32-bit syscall display value and 15-bit PC, snapshots one of them once per scan frame to avoid tearing, and scans it out as hex digits. Leading zeros are blanked, and decimal points mark PC mode and changed values.

## Interface
Parameters:
- CLK_DIV, 100000: clk cycles per digit slot; legal range ≥ 1.
- BLANK_LZ, 1: 1 = blank leading zero digits; 0 = show all 8 digits.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset; asynchronous, active-high.
- display_syscall  in  32  CPU syscall display value.
- display_pc  in  15  CPU PC, low bits.
- sel_pc  in  1  0 = show display_syscall; 1 = show {17'b0, display_pc}.
- an  out  8  digit anodes, active-low one-hot; an[i] drives digit i, where digit 0 is the rightmost, least significant nibble.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point for the active digit, active-low.

## Operation
- div_cnt runs 0..CLK_DIV-1 and wraps to 0. tick = (div_cnt == CLK_DIV-1).
- digit (3 bits) advances on tick and wraps 7→0.
- Frame boundary: tick while digit==7. At the boundary:
  - snap <= sel_pc ? {17'b0, display_pc} : display_syscall.
  - snap_mode <= sel_pc.
  - changed <= (new snap != old snap) or (new mode != old mode).
- Input changes between boundaries have no visible effect until the next boundary.
- nibble = snap[4*d+3 : 4*d], where d is the digit being driven.
- Blanking: digit d > 0 is blank when BLANK_LZ==1 and snap[31:4*d]==0. Digit 0 is never blank.
  - Blank digit: seg = 7'h7F; the anode is still asserted.
- Hex decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dp = 0 on digit 0 when changed==1, and on digit 4 when snap_mode==1. Otherwise dp = 1.
- Output registers: an, seg and dp are registered from the current digit, snap, snap_mode and changed.

## Timing
- Reset values (async, immediate):
  - div_cnt=0, digit=0, snap=0, snap_mode=0, changed=0.
  - an=8'hFF, seg=7'h7F, dp=1.
- First posedge after rst deasserts: an=8'hFE, seg=7'b1000000 (digit 0 of snap=0), dp=1.
- Latency:
  - Output registers lag the digit counter by 1 cycle.
  - Digit slot length = CLK_DIV cycles; frame = 8·CLK_DIV cycles.
  - A new snapshot first appears on the cycle after the boundary tick, with an=8'hFE.
- Before the first boundary, the display shows snap=0 (a single "0") regardless of the inputs.
- CLK_DIV=1: tick every cycle; digit advances every cycle; frame = 8 cycles.
- changed holds for exactly one full frame and is recomputed at every boundary. An unchanged value clears it.
- sel_pc toggling mid-frame takes effect only at the boundary. A toggle with identical numeric value still sets changed (mode change).
- rst asserted mid-frame:
  - All state and outputs clear immediately, without waiting for clk.
  - The scan restarts at digit 0 with div_cnt=0.

## Test plan
- Reset/idle: CLK_DIV=2. Hold rst 3 cycles, release.
  - During rst: an=FF, seg=7F, dp=1.
  - Next posedge: an=FE, seg=1000000.
  - Digits 1..7 blank (seg=7F) for the whole first frame.
- Full hex scan: CLK_DIV=1, display_syscall=32'h89ABCDEF, sel_pc=0.
  - After the boundary, the 8 consecutive cycles show an FE,FD,FB,…,7F.
  - seg over those cycles: F,E,d,C,b,A,9,8 codes.
  - dp=0 on digit 0 for that frame only.
- Leading-zero blanking:
  - value=32'h0000_0A05, BLANK_LZ=1: digits 0..2 show 5,0,A; digits 3..7 show seg=7F.
  - BLANK_LZ=0: all 8 digits shown, digits 3..7 as "0".
- PC mode: sel_pc=1, display_pc=15'h1234.
  - Shows 4,3,2,1 on digits 0..3; digits 4..7 blank (seg=7F).
  - Digit 4 has dp=0.
- Tear-free snapshot: change display_syscall from 32'h11111111 to 32'h22222222 mid-frame.
  - The remainder of the frame still shows 1s.
  - The next frame shows 2s with digit-0 dp=0.
  - The following frame has digit-0 dp=1.
- Async reset mid-scan: assert rst between clk edges at digit 5.
  - an=FF, seg=7F and dp=1 within the same cycle.
  - After release, the scan resumes at digit 0 showing "0".

Source files
------------

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver. A snapshot of the selected value is taken
// once per scan frame so a digit never mixes old and new data mid-scan.
module seg7_scan_display #(
    parameter int CLK_DIV  = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display_syscall,
    input  logic [14:0] display_pc,
    input  logic        sel_pc,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       digit;
    logic [31:0]      snap;
    logic             snap_mode;
    logic             changed;

    logic             tick;
    logic             boundary;
    logic [31:0]      snap_next;
    logic [3:0]       nibble;
    logic [31:0]      upper;
    logic             blank;
    logic [7:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    assign tick      = (div_cnt == DIV_MAX);
    assign boundary  = tick && (digit == 3'd7);
    assign snap_next = sel_pc ? {17'b0, display_pc} : display_syscall;

    always_comb begin
        nibble   = snap[{digit, 2'b00} +: 4];
        upper    = snap >> {digit, 2'b00};
        blank    = (BLANK_LZ == 1) && (digit != 3'd0) && (upper == 32'd0);
        an_next  = ~(8'b1 << digit);
        dp_next  = ~(((digit == 3'd0) && changed) || ((digit == 3'd4) && snap_mode));
        seg_next = 7'h7F;
        if (!blank) begin
            case (nibble)
                4'h0: seg_next = 7'b1000000;
                4'h1: seg_next = 7'b1111001;
                4'h2: seg_next = 7'b0100100;
                4'h3: seg_next = 7'b0110000;
                4'h4: seg_next = 7'b0011001;
                4'h5: seg_next = 7'b0010010;
                4'h6: seg_next = 7'b0000010;
                4'h7: seg_next = 7'b1111000;
                4'h8: seg_next = 7'b0000000;
                4'h9: seg_next = 7'b0010000;
                4'hA: seg_next = 7'b0001000;
                4'hB: seg_next = 7'b0000011;
                4'hC: seg_next = 7'b1000110;
                4'hD: seg_next = 7'b0100001;
                4'hE: seg_next = 7'b0000110;
                default: seg_next = 7'b0001110;
            endcase
        end
    end

    // Outputs are registered from the pre-update digit/snapshot, hence one cycle behind the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            digit     <= 3'd0;
            snap      <= 32'd0;
            snap_mode <= 1'b0;
            changed   <= 1'b0;
            an        <= 8'hFF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                digit <= digit + 3'd1;
            end
            if (boundary) begin
                snap      <= snap_next;
                snap_mode <= sel_pc;
                changed   <= (snap_next != snap) || (sel_pc != snap_mode);
            end
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: three parameterisations share stimulus; a cycle-count based
// model predicts every output each cycle, and directed literal checks pin the model.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] display_syscall = 32'd0;
    logic [14:0] display_pc = 15'd0;
    logic        sel_pc = 1'b0;
    logic [7:0]  an_o  [3];
    logic [6:0]  seg_o [3];
    logic        dp_o  [3];

    int vectors = 0;
    int errors  = 0;
    bit run = 1'b0;

    localparam int DV [3] = '{2, 1, 1};
    localparam int BZ [3] = '{1, 1, 0};

    always #5 clk = ~clk;

    seg7_scan_display #(.CLK_DIV(2), .BLANK_LZ(1)) u_a (
        .clk(clk), .rst(rst), .display_syscall(display_syscall), .display_pc(display_pc),
        .sel_pc(sel_pc), .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0]));
    seg7_scan_display #(.CLK_DIV(1), .BLANK_LZ(1)) u_b (
        .clk(clk), .rst(rst), .display_syscall(display_syscall), .display_pc(display_pc),
        .sel_pc(sel_pc), .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1]));
    seg7_scan_display #(.CLK_DIV(1), .BLANK_LZ(0)) u_c (
        .clk(clk), .rst(rst), .display_syscall(display_syscall), .display_pc(display_pc),
        .sel_pc(sel_pc), .an(an_o[2]), .seg(seg_o[2]), .dp(dp_o[2]));

    function automatic logic [6:0] hex7(logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(logic [31:0] v, int d, int blz);
        logic [31:0] up;
        up = v >> (4 * d);
        if (d > 0 && blz == 1 && up == 32'd0) return 7'h7F;
        return hex7(up[3:0]);
    endfunction

    function automatic logic exp_dp(int d, logic chg, logic mode);
        return !((d == 0 && chg) || (d == 4 && mode));
    endfunction

    function automatic logic [31:0] pick(logic s, logic [14:0] pc, logic [31:0] sys);
        return s ? {17'b0, pc} : sys;
    endfunction

    // Model: cycles since reset decide the digit; every 8*CLK_DIV cycles a fresh snapshot.
    int          m_k    [3] = '{0, 0, 0};
    logic [31:0] m_snap [3] = '{0, 0, 0};
    logic        m_mode [3] = '{0, 0, 0};
    logic        m_chg  [3] = '{0, 0, 0};
    logic [7:0]  e_an   [3] = '{8'hFF, 8'hFF, 8'hFF};
    logic [6:0]  e_seg  [3] = '{7'h7F, 7'h7F, 7'h7F};
    logic        e_dp   [3] = '{1, 1, 1};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_k[i] <= 0; m_snap[i] <= 32'd0; m_mode[i] <= 1'b0; m_chg[i] <= 1'b0;
                e_an[i] <= 8'hFF; e_seg[i] <= 7'h7F; e_dp[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                e_an[i]  <= ~(8'b1 << ((m_k[i] / DV[i]) % 8));
                e_seg[i] <= exp_seg(m_snap[i], (m_k[i] / DV[i]) % 8, BZ[i]);
                e_dp[i]  <= exp_dp((m_k[i] / DV[i]) % 8, m_chg[i], m_mode[i]);
                if (m_k[i] % (8 * DV[i]) == 8 * DV[i] - 1) begin
                    m_snap[i] <= pick(sel_pc, display_pc, display_syscall);
                    m_mode[i] <= sel_pc;
                    m_chg[i]  <= (pick(sel_pc, display_pc, display_syscall) != m_snap[i])
                                 || (sel_pc != m_mode[i]);
                end
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model an[%0d]", i), an_o[i], e_an[i]);
                chk($sformatf("model seg[%0d]", i), {1'b0, seg_o[i]}, {1'b0, e_seg[i]});
                chk($sformatf("model dp[%0d]", i), {7'b0, dp_o[i]}, {7'b0, e_dp[i]});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst an", an_o[0], 8'hFF);
        chk("rst seg", {1'b0, seg_o[0]}, 8'h7F);
        chk("rst dp", {7'b0, dp_o[0]}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [6:0] hex_fe [8] = '{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
                              7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000};
    logic [6:0] lz_on  [8] = '{7'b0010010, 7'b1000000, 7'b0001000, 7'h7F,
                              7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] lz_off [8] = '{7'b0010010, 7'b1000000, 7'b0001000, 7'b1000000,
                              7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

    initial begin
        @(negedge clk);
        run = 1'b1;

        // full hex scan plus idle first frame
        display_syscall = 32'h89ABCDEF;
        do_reset();
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk("first an", an_o[0], 8'hFE);
                chk("first seg", {1'b0, seg_o[0]}, 8'h40);
                chk("first dp", {7'b0, dp_o[0]}, 8'h01);
            end
            if (j <= 16 && (j - 1) / 2 > 0) chk("idle blank", {1'b0, seg_o[0]}, 8'h7F);
            if (j >= 9 && j <= 16) begin
                chk("scan an", an_o[1], ~(8'b1 << (j - 9)));
                chk("scan seg", {1'b0, seg_o[1]}, {1'b0, hex_fe[j - 9]});
                chk("scan dp", {7'b0, dp_o[1]}, (j == 9) ? 8'h00 : 8'h01);
            end
            if (j == 17) begin
                chk("dp cleared", {7'b0, dp_o[1]}, 8'h01);
                chk("div2 new snap seg", {1'b0, seg_o[0]}, 8'h0E);
                chk("div2 new snap dp", {7'b0, dp_o[0]}, 8'h00);
            end
        end

        // leading-zero blanking on/off
        display_syscall = 32'h0000_0A05;
        do_reset();
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j >= 9) begin
                chk("lz on seg", {1'b0, seg_o[1]}, {1'b0, lz_on[j - 9]});
                chk("lz off seg", {1'b0, seg_o[2]}, {1'b0, lz_off[j - 9]});
            end
        end

        // PC mode
        sel_pc = 1'b1;
        display_pc = 15'h1234;
        do_reset();
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 9)  chk("pc digit0", {1'b0, seg_o[1]}, 8'h19);
            if (j == 12) chk("pc digit3", {1'b0, seg_o[1]}, 8'h79);
            if (j == 13) begin
                chk("pc digit4 seg", {1'b0, seg_o[1]}, 8'h7F);
                chk("pc digit4 dp", {7'b0, dp_o[1]}, 8'h00);
            end
        end

        // tear-free snapshot on the CLK_DIV=2 instance
        sel_pc = 1'b0;
        display_syscall = 32'h11111111;
        do_reset();
        for (int j = 1; j <= 49; j++) begin
            @(negedge clk);
            if (j >= 17 && j <= 32) chk("tear old", {1'b0, seg_o[0]}, 8'h79);
            if (j >= 33 && j <= 48) chk("tear new", {1'b0, seg_o[0]}, 8'h24);
            if (j == 33) chk("tear dp set", {7'b0, dp_o[0]}, 8'h00);
            if (j == 49) chk("tear dp clear", {7'b0, dp_o[0]}, 8'h01);
            if (j == 20) display_syscall = 32'h22222222;
        end

        // asynchronous reset mid-scan at digit 5
        display_syscall = 32'h12345678;
        do_reset();
        repeat (27) @(negedge clk);
        chk("pre-rst digit5", {1'b0, seg_o[0]}, 8'h30);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async an", an_o[i], 8'hFF);
            chk("async seg", {1'b0, seg_o[i]}, 8'h7F);
            chk("async dp", {7'b0, dp_o[i]}, 8'h01);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("resume an", an_o[i], 8'hFE);
            chk("resume seg", {1'b0, seg_o[i]}, 8'h40);
        end
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
